// File: rtl/scdaq_pkg.sv
// Shared types and constants for the Single Channel DAQ readout sequencer.
// Contents: sequencer state encoding, the CFG address of the MODE word, and
// the trigger MODE encodings.
package scdaq_pkg;

  // Sequencer states of one acquisition cycle
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CFG_REQ  = 3'd1,
    CFG_DONE = 3'd2,
    RDO_REQ  = 3'd3,
    RDO_REL  = 3'd4,
    OUT      = 3'd5,
    RDO_FIN  = 3'd6
  } state_e;

  // CFG address holding the trigger MODE word
  localparam int unsigned MODE_ADDR  = 0;

  // Trigger MODE encodings
  localparam int unsigned MODE_NOTRG = 0;

endpackage : scdaq_pkg

// File: rtl/scdaq_ack_timer.sv
// Acknowledge watchdog shared by all handshake wait states.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - clear the count (asserted on every state change)
//   en        - count this cycle (sequencer is waiting on an Ack edge)
//   expire_c  - combinational: this is the TIMEOUT-th waiting cycle
module scdaq_ack_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count waiting cycles, saturating at TIMEOUT
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Independent of load so the sequencer's next-state logic has no loop
  assign expire_c = en && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : scdaq_ack_timer

// File: rtl/scdaq_readout_ctrl.sv
// One full acquisition cycle on the Single Channel DAQ: write the MODE word
// over CFG, read NSAMPLES samples over the four-phase RDO handshake, stream
// each sample out on a valid/ready port, then pulse RDO_Done.
// Ports:
//   Clock, Reset                 - 50 MHz clock, synchronous active-high reset
//   Start, Mode                  - cycle start pulse and MODE word (IDLE only)
//   CFG_Req/WREn/Add/D/Done/Ack  - configuration write handshake
//   RDO_Req/Add/Done/Ack/Q       - sample readout handshake
//   Smp_Valid/Last/Data/Index/Ready - sample stream
//   Busy, Error                  - cycle in progress, sticky Ack timeout
module scdaq_readout_ctrl
  import scdaq_pkg::*;
#(
  parameter int unsigned NSAMPLES     = 128,
  parameter int unsigned PRECISION    = 14,
  parameter int unsigned RDO_ADD_BLEN = 7,
  parameter int unsigned CFG_ADD_BLEN = 10,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [PRECISION-1:0]    Mode,
  output logic                    CFG_Req,
  output logic                    CFG_WREn,
  output logic                    CFG_Done,
  output logic [CFG_ADD_BLEN-1:0] CFG_Add,
  output logic [PRECISION-1:0]    CFG_D,
  input  logic                    CFG_Ack,
  output logic                    RDO_Req,
  output logic                    RDO_Done,
  output logic [RDO_ADD_BLEN-1:0] RDO_Add,
  input  logic                    RDO_Ack,
  input  logic [PRECISION-1:0]    RDO_Q,
  output logic                    Smp_Valid,
  output logic                    Smp_Last,
  output logic [PRECISION-1:0]    Smp_Data,
  output logic [RDO_ADD_BLEN-1:0] Smp_Index,
  input  logic                    Smp_Ready,
  output logic                    Busy,
  output logic                    Error
);

  localparam logic [RDO_ADD_BLEN-1:0] LAST_IDX = RDO_ADD_BLEN'(NSAMPLES - 1);

  state_e                  state_q, state_d;
  logic [RDO_ADD_BLEN-1:0] idx_q, idx_d;
  logic [PRECISION-1:0]    cfg_data_q, cfg_data_d;
  logic [PRECISION-1:0]    smp_data_q, smp_data_d;
  logic [RDO_ADD_BLEN-1:0] smp_index_q, smp_index_d;
  logic [RDO_ADD_BLEN-1:0] rdo_add_q, rdo_add_d;
  logic error_q, error_d;
  logic busy_q, busy_d;
  logic cfg_req_q, cfg_req_d;
  logic cfg_done_q, cfg_done_d;
  logic rdo_req_q, rdo_req_d;
  logic rdo_done_q, rdo_done_d;
  logic smp_valid_q, smp_valid_d;
  logic smp_last_q, smp_last_d;

  logic wait_c;
  logic load_c;
  logic expire_c;

  // Waiting on an Ack edge: the only cycles the watchdog may count
  assign wait_c = ((state_q == CFG_REQ) && !CFG_Ack) ||
                  ((state_q == RDO_REQ) && !RDO_Ack) ||
                  ((state_q == RDO_REL) &&  RDO_Ack);
  assign load_c = (state_d != state_q);

  scdaq_ack_timer #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk      (Clock),
    .rst      (Reset),
    .load     (load_c),
    .en       (wait_c),
    .expire_c (expire_c)
  );

  // Next state, datapath, and registered outputs decoded from the next state
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cfg_data_d  = cfg_data_q;
    smp_data_d  = smp_data_q;
    smp_index_d = smp_index_q;
    error_d     = error_q;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d    = CFG_REQ;
          cfg_data_d = Mode;
          error_d    = 1'b0;
        end
      end
      CFG_REQ: begin
        if (CFG_Ack) begin
          state_d = CFG_DONE;
        end else if (expire_c) begin
          state_d = CFG_DONE;
          error_d = 1'b1;
        end
      end
      CFG_DONE: begin
        idx_d = '0;
        // Error here can only come from this cycle's CFG timeout
        state_d = error_q ? IDLE : RDO_REQ;
      end
      RDO_REQ: begin
        if (RDO_Ack) begin
          state_d     = RDO_REL;
          smp_data_d  = RDO_Q;
          smp_index_d = idx_q;
        end else if (expire_c) begin
          state_d = RDO_FIN;
          error_d = 1'b1;
        end
      end
      RDO_REL: begin
        if (!RDO_Ack) begin
          state_d = OUT;
        end else if (expire_c) begin
          state_d = RDO_FIN;
          error_d = 1'b1;
        end
      end
      OUT: begin
        if (Smp_Ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = RDO_FIN;
          end else begin
            idx_d   = idx_q + RDO_ADD_BLEN'(1);
            state_d = RDO_REQ;
          end
        end
      end
      RDO_FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    cfg_req_d   = (state_d == CFG_REQ);
    cfg_done_d  = (state_d == CFG_DONE);
    rdo_req_d   = (state_d == RDO_REQ);
    rdo_done_d  = (state_d == RDO_FIN);
    smp_valid_d = (state_d == OUT);
    smp_last_d  = (state_d == OUT) && (idx_d == LAST_IDX);
    rdo_add_d   = idx_d;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cfg_data_q  <= PRECISION'(MODE_NOTRG);
      smp_data_q  <= '0;
      smp_index_q <= '0;
      rdo_add_q   <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      cfg_req_q   <= 1'b0;
      cfg_done_q  <= 1'b0;
      rdo_req_q   <= 1'b0;
      rdo_done_q  <= 1'b0;
      smp_valid_q <= 1'b0;
      smp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cfg_data_q  <= cfg_data_d;
      smp_data_q  <= smp_data_d;
      smp_index_q <= smp_index_d;
      rdo_add_q   <= rdo_add_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      cfg_req_q   <= cfg_req_d;
      cfg_done_q  <= cfg_done_d;
      rdo_req_q   <= rdo_req_d;
      rdo_done_q  <= rdo_done_d;
      smp_valid_q <= smp_valid_d;
      smp_last_q  <= smp_last_d;
    end
  end

  assign CFG_Req   = cfg_req_q;
  assign CFG_WREn  = cfg_req_q;
  assign CFG_Done  = cfg_done_q;
  assign CFG_Add   = CFG_ADD_BLEN'(MODE_ADDR);
  assign CFG_D     = cfg_data_q;
  assign RDO_Req   = rdo_req_q;
  assign RDO_Done  = rdo_done_q;
  assign RDO_Add   = rdo_add_q;
  assign Smp_Valid = smp_valid_q;
  assign Smp_Last  = smp_last_q;
  assign Smp_Data  = smp_data_q;
  assign Smp_Index = smp_index_q;
  assign Busy      = busy_q;
  assign Error     = error_q;

endmodule : scdaq_readout_ctrl

// File: tb/tb_scdaq_readout_ctrl.sv
// Bench for scdaq_readout_ctrl: CFG/RDO responders, a stream consumer and an
// in-order sample scoreboard built from a sample memory.
`timescale 1ns/1ps
module tb_scdaq_readout_ctrl;

  localparam int unsigned NS = 128;
  localparam int unsigned PW = 14;
  localparam int unsigned AW = 7;
  localparam int unsigned CW = 10;
  localparam int unsigned TO = 255;

  logic          Clock = 1'b0;
  logic          Reset, Start;
  logic [PW-1:0] Mode;
  logic          CFG_Req, CFG_WREn, CFG_Done, CFG_Ack;
  logic [CW-1:0] CFG_Add;
  logic [PW-1:0] CFG_D;
  logic          RDO_Req, RDO_Done, RDO_Ack;
  logic [AW-1:0] RDO_Add;
  logic [PW-1:0] RDO_Q;
  logic          Smp_Valid, Smp_Last, Smp_Ready;
  logic [PW-1:0] Smp_Data;
  logic [AW-1:0] Smp_Index;
  logic          Busy, Error;

  scdaq_readout_ctrl dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode),
    .CFG_Req(CFG_Req), .CFG_WREn(CFG_WREn), .CFG_Done(CFG_Done),
    .CFG_Add(CFG_Add), .CFG_D(CFG_D), .CFG_Ack(CFG_Ack),
    .RDO_Req(RDO_Req), .RDO_Done(RDO_Done), .RDO_Add(RDO_Add),
    .RDO_Ack(RDO_Ack), .RDO_Q(RDO_Q),
    .Smp_Valid(Smp_Valid), .Smp_Last(Smp_Last), .Smp_Data(Smp_Data),
    .Smp_Index(Smp_Index), .Smp_Ready(Smp_Ready),
    .Busy(Busy), .Error(Error)
  );

  always #10 Clock = ~Clock;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  int unsigned   mem [NS];
  logic [PW-1:0] exp_mode;
  int exp_idx, beats;
  int rdo_done_cnt = 0, cfg_done_cnt = 0;
  int to_len, req_len;
  logic to_req, to_done;

  // Stimulus knobs
  int cfg_delay = 0;
  bit cfg_stall = 0;
  int rdo_dmax  = 0;
  int rdo_stall = -1;
  bit rand_ready = 0;
  int ready_stall_idx = -1;
  bit stalled;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // CFG responder: Ack after cfg_delay cycles of Req, dropped when Req falls
  initial begin
    int cd;
    CFG_Ack = 1'b0;
    cd = 0;
    forever begin
      @(posedge Clock); #1;
      if (Reset) begin
        CFG_Ack = 1'b0; cd = 0;
      end else if (CFG_Req && !CFG_Ack && !cfg_stall) begin
        if (cd >= cfg_delay) begin CFG_Ack = 1'b1; cd = 0; end
        else cd++;
      end else if (!CFG_Req) begin
        CFG_Ack = 1'b0;
      end
    end
  end

  // RDO responder: four-phase, random Ack latency, never acks rdo_stall
  initial begin
    int rd, rd_tgt;
    RDO_Ack = 1'b0; RDO_Q = '0; rd = 0; rd_tgt = 0;
    forever begin
      @(posedge Clock); #1;
      if (Reset) begin
        RDO_Ack = 1'b0; rd = 0;
      end else if (RDO_Req && !RDO_Ack) begin
        if (int'(RDO_Add) != rdo_stall) begin
          if (rd >= rd_tgt) begin
            RDO_Ack = 1'b1;
            RDO_Q   = PW'(mem[RDO_Add]);
            rd      = 0;
            rd_tgt  = $urandom_range(rdo_dmax, 0);
          end else rd++;
        end
      end else if (!RDO_Req && RDO_Ack) begin
        RDO_Ack = 1'b0;
        RDO_Q   = PW'($urandom);
      end
    end
  end

  // Stream consumer: constant, random, or a 10-cycle stall at one index
  initial begin
    int hold;
    Smp_Ready = 1'b0; hold = 0;
    forever begin
      @(posedge Clock); #1;
      if (hold > 0) begin
        Smp_Ready = 1'b0; hold--;
      end else if (Smp_Valid && !stalled && ready_stall_idx >= 0 &&
                   int'(Smp_Index) == ready_stall_idx) begin
        Smp_Ready = 1'b0; hold = 9; stalled = 1'b1;
      end else begin
        Smp_Ready = rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
      end
    end
  end

  // Scoreboard and protocol monitor, sampled mid-cycle
  initial begin
    bit cfg_done_prev, rdo_done_prev, err_prev;
    cfg_done_prev = 0; rdo_done_prev = 0; err_prev = 0; req_len = 0;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        cfg_done_prev = 0; rdo_done_prev = 0; req_len = 0;
      end else begin
        if (CFG_Req) begin
          chk("cfg_add", CFG_Add, 0);
          chk("cfg_wren", CFG_WREn, 1);
          chk("cfg_d", CFG_D, exp_mode);
        end
        if (cfg_done_prev && !Error) chk("rdo_req_after_cfg", {RDO_Req, RDO_Add}, {1'b1, 7'd0});
        if (CFG_Done) begin
          chk("cfg_done_width", cfg_done_prev, 0);
          cfg_done_cnt++;
        end
        if (RDO_Done) begin
          chk("rdo_done_width", rdo_done_prev, 0);
          rdo_done_cnt++;
        end
        if (Smp_Valid) begin
          chk("smp_index", Smp_Index, exp_idx);
          chk("smp_data", Smp_Data, mem[exp_idx % NS]);
          chk("smp_last", Smp_Last, (exp_idx == NS - 1));
          chk("rdo_req_in_out", RDO_Req, 0);
          if (Smp_Ready) begin
            beats++; exp_idx++;
          end
        end
        if (Error && !err_prev) begin
          to_len = req_len; to_req = RDO_Req; to_done = RDO_Done;
        end
        req_len = RDO_Req ? req_len + 1 : 0;
        cfg_done_prev = CFG_Done;
        rdo_done_prev = RDO_Done;
      end
      err_prev = Error;
    end
  end

  task automatic start_pulse(input logic [PW-1:0] mode);
    exp_mode = mode; exp_idx = 0; beats = 0; stalled = 1'b0;
    Mode = mode; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    Mode  = PW'($urandom);
  endtask

  task automatic run_cycle(input logic [PW-1:0] mode, input int poke_idx,
                           input int exp_beats, input int exp_rdone, input bit exp_err);
    int n, d0, c0;
    bit poked;
    d0 = rdo_done_cnt; c0 = cfg_done_cnt; poked = 1'b0;
    start_pulse(mode);
    chk("start_busy", Busy, 1);
    chk("start_cfg_req", CFG_Req, 1);
    chk("start_err_clr", Error, 0);
    n = 0;
    while (Busy && n < 20000) begin
      Start = (poke_idx >= 0) && !poked && Smp_Valid && (int'(Smp_Index) == poke_idx);
      if (Start) poked = 1'b1;
      @(posedge Clock); #1;
      n++;
    end
    Start = 1'b0;
    chk("cycle_bound", (n < 20000), 1);
    if (poke_idx >= 0) chk("poke_applied", poked, 1);
    chk("beats", beats, exp_beats);
    chk("rdo_done_cnt", rdo_done_cnt - d0, exp_rdone);
    chk("cfg_done_cnt", cfg_done_cnt - c0, 1);
    chk("error_end", Error, exp_err);
  endtask

  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < int'(NS); i++) mem[i] = ramp ? 100 + i : $urandom_range(16383, 0);
  endtask

  // Watchdog
  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, d0;
    Reset = 1'b1; Start = 1'b1; Mode = PW'($urandom);
    exp_mode = '0; exp_idx = 0; beats = 0; stalled = 1'b0;
    to_len = 0; to_req = 1'b1; to_done = 1'b0;
    fill_mem(1'b1);

    // 1: reset with Start held, then MODE=NOTRG, CFG Ack after 3 cycles
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_flags", {Busy, Error, CFG_Req, CFG_WREn, CFG_Done, RDO_Req,
                      RDO_Done, Smp_Valid, Smp_Last}, 0);
    chk("rst_cfg_d", CFG_D, 0);
    chk("rst_smp", {Smp_Data, Smp_Index, RDO_Add}, 0);
    Reset = 1'b0; Start = 1'b0;
    @(posedge Clock); #1;
    chk("idle_after_rst", Busy, 0);
    cfg_delay = 3;

    // 2: ramp data, Ack after one cycle, Ready constantly high
    run_cycle(PW'(0), -1, NS, 1, 0);

    // 3: 10-cycle backpressure at index 5, random Ack latency
    cfg_delay = 0; rdo_dmax = 2; ready_stall_idx = 5;
    fill_mem(1'b0);
    run_cycle(PW'($urandom), -1, NS, 1, 0);
    ready_stall_idx = -1;

    // 4: RDO Ack never arrives at index 3, then a clean retry
    rdo_stall = 3; to_len = 0;
    run_cycle(PW'($urandom), -1, 3, 1, 1);
    chk("timeout_len", to_len, TO);
    chk("timeout_req_low", to_req, 0);
    chk("timeout_done", to_done, 1);
    rdo_stall = -1;
    run_cycle(PW'($urandom), -1, NS, 1, 0);

    // CFG Ack never arrives: CFG_Done with Error, no readout
    cfg_stall = 1'b1;
    run_cycle(PW'($urandom), -1, 0, 0, 1);
    cfg_stall = 1'b0;

    // 5: reset while presenting index 40
    fill_mem(1'b0);
    d0 = rdo_done_cnt;
    start_pulse(PW'($urandom));
    n = 0;
    while (!(Smp_Valid && Smp_Index == AW'(40)) && n < 5000) begin
      @(posedge Clock); #1; n++;
    end
    chk("reach_idx40", (n < 5000), 1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("midrst_flags", {Busy, Error, CFG_Req, CFG_WREn, CFG_Done, RDO_Req,
                         RDO_Done, Smp_Valid, Smp_Last}, 0);
    chk("midrst_data", {CFG_D, Smp_Data, Smp_Index, RDO_Add}, 0);
    Reset = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk("midrst_no_done", rdo_done_cnt - d0, 0);
    run_cycle(PW'($urandom), -1, NS, 1, 0);

    // 6: Start while busy at index 64 is ignored
    run_cycle(PW'($urandom), 64, NS, 1, 0);

    // Randomized cycles: random data, latencies and backpressure
    rand_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      fill_mem(1'b0);
      cfg_delay = $urandom_range(4, 0);
      rdo_dmax  = $urandom_range(3, 0);
      run_cycle(PW'($urandom), -1, NS, 1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_scdaq_readout_ctrl
